cursor_ctrl: RTL and testbench

Cursor position and pen controller for the drawing application. Moves the cursor once per video frame from directional button inputs, with press-and-hold auto-repeat, and clamps it inside the white border of the drawing area. While the pen is down it issues one framebuffer pixel-write request per frame over a valid/ready handshake. The block sits between the user-input synchronisers and the framebuffer write port, and drives the cursor coordinates consumed by the cursor overlay.

---
 rtl/cursor_ctrl_if.sv | 11 +
 rtl/cursor_ctrl.sv | 122 ++++++++++++
 tb/tb_cursor_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/cursor_ctrl_if.sv
// Framebuffer pixel-write handshake between the cursor controller and the framebuffer port.
interface cursor_ctrl_if;
  logic        wr_req;
  logic [10:0] wr_x;
  logic [10:0] wr_y;
  logic [23:0] wr_color;
  logic        wr_ack;

  modport master (output wr_req, output wr_x, output wr_y, output wr_color, input wr_ack);
  modport slave  (input wr_req, input wr_x, input wr_y, input wr_color, output wr_ack);
endinterface

// File: rtl/cursor_ctrl.sv
// Per-frame cursor mover with hold auto-repeat and border clamping; issues one
// pixel write per frame while the pen (or eraser) is down.
module cursor_ctrl #(
  parameter int H          = 480,
  parameter int W          = 640,
  parameter int HOLD_DELAY = 15,
  parameter int REPEAT     = 3,
  parameter int STEP_FAST  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  input  logic        fast,
  input  logic        draw,
  input  logic        erase,
  input  logic [23:0] pen_color,
  output logic [10:0] cursorX,
  output logic [10:0] cursorY,
  output logic        busy,
  cursor_ctrl_if.master wr
);

  localparam int RMAX = (HOLD_DELAY > REPEAT) ? HOLD_DELAY : REPEAT;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic signed [11:0] XMAX = 12'(W - 2);
  localparam logic signed [11:0] YMAX = 12'(H - 2);
  localparam logic signed [11:0] PMIN = 12'sd1;

  typedef enum logic {IDLE, PLOT} state_t;

  state_t        state_q;
  logic [10:0]   cx_q, cy_q;
  logic [RW-1:0] rep_q;
  logic          repeating_q;
  logic          wr_req_q, busy_q;
  logic [10:0]   wr_x_q, wr_y_q;
  logic [23:0]   wr_color_q;

  logic               held, do_move;
  logic signed [11:0] s, dx, dy, nx, ny;
  logic [10:0]        cx_d, cy_d;

  // Signed step per axis, then clamp so the cursor never sits on the white border.
  always_comb begin
    held = up | down | left | right;
    s    = fast ? 12'(STEP_FAST) : 12'sd1;
    dx   = 12'sd0;
    dy   = 12'sd0;
    if (right && !left) dx = s;
    if (left && !right) dx = -s;
    if (down && !up)    dy = s;
    if (up && !down)    dy = -s;
    nx = $signed({1'b0, cx_q}) + dx;
    ny = $signed({1'b0, cy_q}) + dy;
    if (nx < PMIN) nx = PMIN;
    if (nx > XMAX) nx = XMAX;
    if (ny < PMIN) ny = PMIN;
    if (ny > YMAX) ny = YMAX;
    do_move = held && (rep_q == '0);
    cx_d    = do_move ? nx[10:0] : cx_q;
    cy_d    = do_move ? ny[10:0] : cy_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cx_q        <= 11'(W / 2);
      cy_q        <= 11'(H / 2);
      rep_q       <= '0;
      repeating_q <= 1'b0;
      wr_req_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_x_q      <= '0;
      wr_y_q      <= '0;
      wr_color_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (frame_start) begin
          if (!held) begin
            rep_q       <= '0;
            repeating_q <= 1'b0;
          end else if (rep_q == '0) begin
            rep_q       <= repeating_q ? RW'(REPEAT) : RW'(HOLD_DELAY);
            repeating_q <= 1'b1;
          end else begin
            rep_q <= rep_q - 1'b1;
          end
          cx_q <= cx_d;
          cy_q <= cy_d;
          // Write lands on the post-move position, every tick the pen is down.
          if (erase || draw) begin
            wr_x_q     <= cx_d;
            wr_y_q     <= cy_d;
            wr_color_q <= erase ? 24'h000000 : pen_color;
            wr_req_q   <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= PLOT;
          end
        end
        PLOT: if (wr.wr_ack) begin
          wr_req_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cursorX     = cx_q;
  assign cursorY     = cy_q;
  assign busy        = busy_q;
  assign wr.wr_req   = wr_req_q;
  assign wr.wr_x     = wr_x_q;
  assign wr.wr_y     = wr_y_q;
  assign wr.wr_color = wr_color_q;

endmodule

// File: tb/tb_cursor_ctrl.sv
// Directed bench for cursor_ctrl: reset, hold auto-repeat, clamping, pen writes, handshake.
module tb_cursor_ctrl;
  logic        clk, reset, frame_start;
  logic        up, down, left, right, fast, draw, erase;
  logic [23:0] pen_color;
  logic [10:0] cursorX, cursorY;
  logic        busy;
  int          checks, failures;
  int          hi_cnt, rise_cnt;
  logic        mon_en, prev_req;

  cursor_ctrl_if wif();

  cursor_ctrl dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .up(up), .down(down), .left(left), .right(right),
    .fast(fast), .draw(draw), .erase(erase), .pen_color(pen_color),
    .cursorX(cursorX), .cursorY(cursorY), .busy(busy), .wr(wif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon_en) begin
      if (wif.wr_req) hi_cnt++;
      if (wif.wr_req && !prev_req) rise_cnt++;
    end
    prev_req = wif.wr_req;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic tick1();
    frame_start = 1'b1; step(); frame_start = 1'b0;
  endtask

  task automatic tick();
    tick1(); step();
  endtask

  task automatic tap(input logic u, input logic d, input logic l, input logic r, input logic f);
    up = u; down = d; left = l; right = r; fast = f;
    tick();
    up = 0; down = 0; left = 0; right = 0; fast = 0;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1; #2; reset = 1'b0; step();
  endtask

  initial begin
    checks = 0; failures = 0; hi_cnt = 0; rise_cnt = 0; mon_en = 0; prev_req = 0;
    reset = 0; frame_start = 0; up = 0; down = 0; left = 0; right = 0;
    fast = 0; draw = 0; erase = 0; pen_color = '0; wif.wr_ack = 0;
    #2 reset = 1'b1;
    #1;
    chk("rst_x", 32'(cursorX), 320);
    chk("rst_y", 32'(cursorY), 240);
    chk("rst_req", 32'(wif.wr_req), 0);
    chk("rst_busy", 32'(busy), 0);
    step(); reset = 1'b0; step();

    // Hold right for 25 ticks: moves on ticks 1, 17, 21, 25
    right = 1;
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (i == 1)  chk("hold_t1", 32'(cursorX), 321);
      if (i == 16) chk("hold_t16", 32'(cursorX), 321);
      if (i == 17) chk("hold_t17", 32'(cursorX), 322);
      if (i == 20) chk("hold_t20", 32'(cursorX), 322);
      if (i == 21) chk("hold_t21", 32'(cursorX), 323);
    end
    chk("hold_t25", 32'(cursorX), 324);
    right = 0; tick();
    right = 1; tick();
    chk("repress", 32'(cursorX), 325);
    right = 0; tick();

    // Walk to the left border and clamp
    for (int i = 0; i < 40; i++) tap(0, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) tap(0, 0, 1, 0, 0);
    chk("at_x2", 32'(cursorX), 2);
    tap(0, 0, 1, 0, 1);
    chk("clamp_lo", 32'(cursorX), 1);
    for (int i = 0; i < 79; i++) tap(0, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) tap(0, 0, 0, 1, 0);
    chk("at_x637", 32'(cursorX), 637);
    tap(0, 0, 0, 1, 0);
    chk("x638", 32'(cursorX), 638);
    tap(0, 0, 0, 1, 1);
    chk("clamp_hi", 32'(cursorX), 638);
    tap(1, 1, 0, 0, 0);
    chk("updown_y", 32'(cursorY), 240);
    tap(1, 0, 0, 0, 0);
    chk("up_y", 32'(cursorY), 239);

    // Draw with a right tick, stalled acknowledge
    do_reset();
    draw = 1; pen_color = 24'h00FF00; right = 1;
    tick1();
    chk("wr_req_t1", 32'(wif.wr_req), 1);
    chk("wr_x", 32'(wif.wr_x), 321);
    chk("wr_y", 32'(wif.wr_y), 240);
    chk("wr_color", 32'(wif.wr_color), 32'h00FF00);
    chk("busy_plot", 32'(busy), 1);
    pen_color = 24'h123456;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) tick1(); else step();
      chk("stall_req", 32'(wif.wr_req), 1);
      chk("stall_x", 32'(wif.wr_x), 321);
      chk("stall_color", 32'(wif.wr_color), 32'h00FF00);
      chk("stall_cur", 32'(cursorX), 321);
    end
    chk("stall_busy", 32'(busy), 1);
    wif.wr_ack = 1; step(); wif.wr_ack = 0;
    chk("ack_req", 32'(wif.wr_req), 0);
    chk("ack_busy", 32'(busy), 0);
    right = 0; step();

    // Erase priority, stationary pen writes each tick
    erase = 1; pen_color = 24'hABCDEF;
    tick1();
    chk("erase_color", 32'(wif.wr_color), 0);
    chk("erase_x", 32'(wif.wr_x), 321);
    wif.wr_ack = 1; step(); wif.wr_ack = 0;
    erase = 0;
    tick1();
    chk("still_req", 32'(wif.wr_req), 1);
    chk("still_x", 32'(wif.wr_x), 321);
    chk("still_y", 32'(wif.wr_y), 240);
    chk("still_color", 32'(wif.wr_color), 32'hABCDEF);
    wif.wr_ack = 1; step();

    // Ack tied high: ten ticks give ten one-cycle pulses
    step();
    mon_en = 1;
    for (int i = 0; i < 10; i++) begin tick1(); step(); step(); end
    mon_en = 0;
    chk("pulse_hi", 32'(hi_cnt), 10);
    chk("pulse_rise", 32'(rise_cnt), 10);

    // Async reset abandons a pending write
    wif.wr_ack = 0;
    tick1();
    chk("pre_rst_req", 32'(wif.wr_req), 1);
    #2 reset = 1'b1;
    #1;
    chk("async_req", 32'(wif.wr_req), 0);
    chk("async_busy", 32'(busy), 0);
    chk("async_x", 32'(cursorX), 320);
    draw = 0;
    step(); reset = 1'b0; step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
